mdu_iter: RTL
=============

Name: mdu_iter

Overview:
- Iterative 64-bit multiply/divide unit; the responder on the execute-stage mul/div operand-lock handshake.
- Accepts a one-cycle start pulse with operands, and raises a per-operation stall request until the result is ready.
- Returns a 128-bit result: mul gives hi:lo product; div gives remainder:quotient.
- Sits in EX beside the ALU. Its stall-request outputs feed the operand lock and the pipeline stall controller.

Parameters:
- XLEN, 64, operand width; result is 2*XLEN.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: rst_n, synchronous, active-low; clock clk
- flush  in  1  abort the in-flight operation (pipeline flush/exception)
- mul_en  in  1  start-multiply pulse (already masked to one cycle upstream)
- div_en  in  1  start-divide pulse
- is_signed  in  1  treat a and b as two's complement; sampled only on start
- a  in  XLEN  multiplicand / dividend; sampled only on start
- b  in  XLEN  multiplier / divisor; sampled only on start
- stallreq_for_mul  out  1  multiply in progress, hold the pipeline
- stallreq_for_div  out  1  divide in progress, hold the pipeline
- ready  out  1  result valid; held until the next start or flush
- result  out  2*XLEN  mul: {hi,lo} product; div: {remainder,quotient}

Behaviour:
- FSM states: IDLE, MUL, DIV, DONE.
- Reset (sync, rst_n=0): state=IDLE, counter=0, result=0, ready=0. Both stallreqs are low after reset. Reset mid-operation aborts immediately.
- Start: accepted in IDLE or DONE when mul_en or div_en=1.
  - mul_en has priority if both are high.
  - en in MUL/DIV is ignored.
  - Start cycle T captures |a|, |b| (magnitudes when is_signed), sign flags and op; clears ready.
- Stall requests are combinational:
  - stallreq_for_mul = (mul_en & state∈{IDLE,DONE}) | state==MUL.
  - stallreq_for_div = (div_en & !mul_en & state∈{IDLE,DONE}) | state==DIV.
  - This makes the stall visible in start cycle T.
- MUL: shift-add, one multiplier bit per cycle, XLEN cycles (T+1..T+XLEN).
  - Enters DONE at T+XLEN+1; stallreq low, ready=1.
  - Product is negated at the finish step if the sign flags differ.
- DIV: restoring division, one quotient bit per cycle, XLEN cycles, DONE at T+XLEN+1.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend sign.
- Div special cases, detected at start; they skip DIV and go to DONE at T+1:
  - b==0: quotient=all ones, remainder=a (raw).
  - is_signed & a==MIN & b==-1: quotient=MIN, remainder=0.
- DONE: result and ready hold stable indefinitely; this covers downstream stall[2] holding the lock. A new start leaves DONE.
- flush: in any state returns to IDLE next cycle with ready=0 and result unchanged; stallreq low from that cycle.
  - flush wins over a simultaneous en; no operation starts.
- Unsigned mode: a and b are used as-is; no sign fix-up.

Optional Feature:
- MDU_EARLY_OUT_EN defined: MUL terminates once the remaining shifted multiplier bits are all zero, entering DONE the following cycle.
  - Minimum latency is T+2, e.g. b=1 or b=0.
  - DIV latency is unchanged.
- Undefined: MUL always takes the full XLEN iterations.

Test Plan:
- Signed mul a=3, b=-5 → stallreq_for_mul high T..T+64 (65 cycles); ready at T+65; result=0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1; result holds while en stays low.
- Unsigned div a=100, b=7 → stallreq_for_div high 65 cycles; result hi=2, lo=14. Signed div a=-100, b=7 → hi=-2, lo=-14.
- Div a=5, b=0 → ready at T+1, stallreq_for_div high for 1 cycle only; result={5, 0xFFFF_FFFF_FFFF_FFFF}. Signed a=0x8000_0000_0000_0000, b=-1 → {0, 0x8000_0000_0000_0000} at T+1.
- mul_en and div_en both high at T → multiply performed, stallreq_for_div stays low. An en pulse at T+10 is ignored; the result is unchanged.
- flush at T+20 of a div → state IDLE and both stallreqs low at T+21, ready=0. A new mul at T+22 completes normally at T+87.
- With MDU_EARLY_OUT_EN: unsigned mul a=9, b=1 → ready at T+2 with result 9. Without the macro → ready at T+65.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative XLEN-bit multiply/divide unit for the execute stage.
// A one-cycle mul_en/div_en pulse starts an operation. The unit requests a stall
// for as long as the result is not ready.
// Multiply uses shift-add, one multiplier bit per cycle.
// Divide uses restoring division, one quotient bit per cycle.
// Signed operands are reduced to magnitudes at start, and the signs are fixed up
// on the last step.
// Optional build macro MDU_EARLY_OUT_EN: multiply stops as soon as no multiplier
// bits remain to be processed.

module mdu_iter #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              mul_en,
    input  logic              div_en,
    input  logic              is_signed,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              stallreq_for_mul,
    output logic              stallreq_for_div,
    output logic              ready,
    output logic [2*XLEN-1:0] result
);

    localparam int unsigned      W2      = 2 * XLEN;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  XMin    = {1'b1, {(XLEN - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [W2-1:0]     opa_q;     // mul: shifting multiplicand; div: low half is dividend/quotient
    logic [XLEN-1:0]   opb_q;     // mul: shifting multiplier; div: divisor
    logic [W2-1:0]     acc_q;     // mul: partial product; div: low half is partial remainder
    logic              neg_lo_q;  // negate product, or quotient
    logic              neg_hi_q;  // negate remainder
    logic              ready_q;
    logic [W2-1:0]     result_q;

    logic              idle_like;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_by_zero, div_ovf;
    logic [W2-1:0]     mul_sum, mul_res;
    logic              mul_last;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   rem_next, quo_next, rem_fin, quo_fin;

    // Start-time operand conditioning and special-case detection
    always_comb begin
        idle_like   = (state_q == StIdle) || (state_q == StDone);
        sign_a      = is_signed & a[XLEN-1];
        sign_b      = is_signed & b[XLEN-1];
        mag_a       = sign_a ? -a : a;
        mag_b       = sign_b ? -b : b;
        div_by_zero = (b == '0);
        div_ovf     = is_signed && (a == XMin) && (b == '1);
    end

    // One shift-add / restoring-divide step plus the final sign fix-up
    always_comb begin
        mul_sum  = opb_q[0] ? (acc_q + opa_q) : acc_q;
        mul_res  = neg_lo_q ? -mul_sum : mul_sum;
`ifdef MDU_EARLY_OUT_EN
        mul_last = (cnt_q == CntLast) || (opb_q[XLEN-1:1] == '0);
`else
        mul_last = (cnt_q == CntLast);
`endif
        div_shift = {acc_q[XLEN-1:0], opa_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        // The partial remainder is always below the divisor, so the difference fits in XLEN bits
        rem_next  = div_ge ? (div_shift[XLEN-1:0] - opb_q) : div_shift[XLEN-1:0];
        quo_next  = {opa_q[XLEN-2:0], div_ge};
        quo_fin   = neg_lo_q ? -quo_next : quo_next;
        rem_fin   = neg_hi_q ? -rem_next : rem_next;
    end

    // Stall requests are combinational so the pipeline holds in the start cycle itself
    always_comb begin
        stallreq_for_mul = (mul_en & idle_like) | (state_q == StMul);
        stallreq_for_div = (div_en & ~mul_en & idle_like) | (state_q == StDiv);
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            // Abort; the last result stays visible but is no longer flagged valid
            state_q <= StIdle;
            ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (mul_en || div_en) begin
                        ready_q  <= 1'b0;
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        opa_q    <= {{XLEN{1'b0}}, mag_a};
                        opb_q    <= mag_b;
                        neg_lo_q <= sign_a ^ sign_b;
                        neg_hi_q <= sign_a;
                        if (mul_en) begin
                            state_q <= StMul;
                        end else if (div_by_zero) begin
                            result_q <= {a, {XLEN{1'b1}}};
                            ready_q  <= 1'b1;
                            state_q  <= StDone;
                        end else if (div_ovf) begin
                            result_q <= {{XLEN{1'b0}}, XMin};
                            ready_q  <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            state_q <= StDiv;
                        end
                    end
                end
                StMul: begin
                    acc_q <= mul_sum;
                    opa_q <= opa_q << 1;
                    opb_q <= opb_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (mul_last) begin
                        result_q <= mul_res;
                        ready_q  <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StDiv: begin
                    acc_q <= {{XLEN{1'b0}}, rem_next};
                    opa_q <= {opa_q[W2-1:XLEN], quo_next};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CntLast) begin
                        result_q <= {rem_fin, quo_fin};
                        ready_q  <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready  = ready_q;
    assign result = result_q;

endmodule
